msx_ps2_keymatrix: RTL and testbench

- Keyboard front end feeding the PPI: consumes the row select the CPU writes to port C[3:0] and returns the active-low column byte read on port B.
- Receives raw PS/2 (scan code set 2) from the host keyboard and maintains an 11x8 MSX key matrix.
- Sits between the PS/2 pins and `jt8255.portb_din`; the row input is `jt8255.portc_dout[3:0]`.

---
 rtl/msx_ps2_keymatrix_pkg.sv | 76 +++++++
 rtl/msx_ps2_keymatrix_ps2_rx.sv | 122 ++++++++++++
 rtl/msx_ps2_keymatrix.sv | 99 +++++++++
 tb/tb_msx_ps2_keymatrix.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/msx_ps2_keymatrix_pkg.sv
// ============================================================================
// msx_kbd_pkg : shared types, PS/2 prefix codes and the set-2 -> MSX matrix map
// Revision    : 1.0
// ============================================================================
`default_nettype none

package msx_kbd_pkg;

    typedef struct packed {
        logic       valid;
        logic [3:0] row;
        logic [2:0] col;
    } kbd_pos_t;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    localparam logic [7:0] c_code_ext   = 8'hE0;
    localparam logic [7:0] c_code_brk   = 8'hF0;
    localparam logic [7:0] c_code_pause = 8'hE1;
    localparam logic [2:0] c_pause_skip = 3'd7;

    // Keyboard responses (BAT ok, echo, ack, resend, overrun) carry no key info.
    function automatic logic is_ignored(input logic [7:0] code);
        return (code == 8'hAA) || (code == 8'hEE) || (code == 8'hFA) ||
               (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);
    endfunction

    function automatic kbd_pos_t pos(input int r, input int c);
        kbd_pos_t p;
        p.valid = 1'b1;
        p.row   = 4'(r);
        p.col   = 3'(c);
        return p;
    endfunction

    function automatic kbd_pos_t map_ps2(input logic ext, input logic [7:0] code);
        kbd_pos_t p;
        p = '0;
        case ({ext, code})
            9'h045: p = pos(0,0); 9'h016: p = pos(0,1); 9'h01E: p = pos(0,2); 9'h026: p = pos(0,3);
            9'h025: p = pos(0,4); 9'h02E: p = pos(0,5); 9'h036: p = pos(0,6); 9'h03D: p = pos(0,7);
            9'h03E: p = pos(1,0); 9'h046: p = pos(1,1); 9'h04E: p = pos(1,2); 9'h055: p = pos(1,3);
            9'h05D: p = pos(1,4); 9'h054: p = pos(1,5); 9'h05B: p = pos(1,6); 9'h04C: p = pos(1,7);
            9'h052: p = pos(2,0); 9'h00E: p = pos(2,1); 9'h041: p = pos(2,2); 9'h049: p = pos(2,3);
            9'h04A: p = pos(2,4); 9'h00B: p = pos(2,5); 9'h01C: p = pos(2,6); 9'h032: p = pos(2,7);
            9'h021: p = pos(3,0); 9'h023: p = pos(3,1); 9'h024: p = pos(3,2); 9'h02B: p = pos(3,3);
            9'h034: p = pos(3,4); 9'h033: p = pos(3,5); 9'h043: p = pos(3,6); 9'h03B: p = pos(3,7);
            9'h042: p = pos(4,0); 9'h04B: p = pos(4,1); 9'h03A: p = pos(4,2); 9'h031: p = pos(4,3);
            9'h044: p = pos(4,4); 9'h04D: p = pos(4,5); 9'h015: p = pos(4,6); 9'h02D: p = pos(4,7);
            9'h01B: p = pos(5,0); 9'h02C: p = pos(5,1); 9'h03C: p = pos(5,2); 9'h02A: p = pos(5,3);
            9'h01D: p = pos(5,4); 9'h022: p = pos(5,5); 9'h035: p = pos(5,6); 9'h01A: p = pos(5,7);
            9'h012: p = pos(6,0); 9'h059: p = pos(6,0); 9'h014: p = pos(6,1); 9'h114: p = pos(6,1);
            9'h011: p = pos(6,2); 9'h058: p = pos(6,3); 9'h111: p = pos(6,4); 9'h005: p = pos(6,5);
            9'h006: p = pos(6,6); 9'h004: p = pos(6,7);
            9'h00C: p = pos(7,0); 9'h003: p = pos(7,1); 9'h076: p = pos(7,2); 9'h00D: p = pos(7,3);
            9'h00A: p = pos(7,4); 9'h066: p = pos(7,5); 9'h083: p = pos(7,6); 9'h05A: p = pos(7,7);
            9'h15A: p = pos(7,7);
            9'h029: p = pos(8,0); 9'h16C: p = pos(8,1); 9'h170: p = pos(8,2); 9'h171: p = pos(8,3);
            9'h16B: p = pos(8,4); 9'h175: p = pos(8,5); 9'h172: p = pos(8,6); 9'h174: p = pos(8,7);
            9'h07C: p = pos(9,0); 9'h079: p = pos(9,1); 9'h14A: p = pos(9,2); 9'h070: p = pos(9,3);
            9'h069: p = pos(9,4); 9'h072: p = pos(9,5); 9'h07A: p = pos(9,6); 9'h06B: p = pos(9,7);
            9'h073: p = pos(10,0); 9'h074: p = pos(10,1); 9'h06C: p = pos(10,2); 9'h075: p = pos(10,3);
            9'h07D: p = pos(10,4); 9'h07B: p = pos(10,5); 9'h071: p = pos(10,7);
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/msx_ps2_keymatrix_ps2_rx.sv
// ============================================================================
// ps2_rx : PS/2 line conditioning, 11-bit frame receiver and frame watchdog
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_rx
    import msx_kbd_pkg::*;
#(
    parameter int          FILT    = 8,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_err
);

    localparam int c_fw = $clog2(FILT) + 1;

    logic [1:0]      r_clk_sync;
    logic [1:0]      r_dat_sync;
    logic            r_clk_filt;
    logic [c_fw-1:0] r_fcnt;
    rx_state_t       r_state;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_par;
    logic [15:0]     r_wdog;
    logic            w_flip;
    logic            w_strobe;
    logic            w_dat;

    assign w_dat    = r_dat_sync[1];
    assign w_flip   = (r_clk_sync[1] != r_clk_filt) && (r_fcnt == c_fw'(FILT - 1));
    // Filtered level is about to drop from 1 to 0: the sample strobe.
    assign w_strobe = w_flip && r_clk_filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_filt <= 1'b1;
            r_fcnt     <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            if (r_clk_sync[1] == r_clk_filt) begin
                r_fcnt <= '0;
            end else if (w_flip) begin
                r_clk_filt <= r_clk_sync[1];
                r_fcnt     <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RX_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_wdog   <= '0;
            rx_valid <= 1'b0;
            rx_byte  <= '0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (r_state == RX_IDLE || w_strobe) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + 16'd1;
            end

            if (r_state != RX_IDLE && !w_strobe && r_wdog == TIMEOUT) begin
                r_state <= RX_IDLE;
                rx_err  <= 1'b1;
            end else if (w_strobe) begin
                case (r_state)
                    RX_IDLE: begin
                        if (!w_dat) begin
                            r_state  <= RX_DATA;
                            r_bitcnt <= '0;
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        r_shift  <= {w_dat, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        r_par   <= w_dat;
                        r_state <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (w_dat && (^{r_shift, r_par})) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= r_shift;
                        end else begin
                            rx_err <= 1'b1;
                        end
                        r_state <= RX_IDLE;
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/msx_ps2_keymatrix.sv
// ============================================================================
// msx_ps2_keymatrix : PS/2 set-2 keyboard to MSX 11x8 key matrix for PPI port B
// Revision          : 1.0
// ============================================================================
`default_nettype none

module msx_ps2_keymatrix
    import msx_kbd_pkg::*;
#(
    parameter int          FILT    = 8,
    parameter logic [15:0] TIMEOUT = 16'd50000,
    parameter int          ROWS    = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [3:0] row,
    output logic [7:0] cols,
    output logic       rx_err,
    output logic       key_evt
);

    logic       w_rx_valid;
    logic [7:0] w_rx_byte;
    kbd_pos_t   w_pos;
    logic [7:0] w_cols;
    logic [7:0] r_matrix [ROWS];
    logic       r_ext;
    logic       r_brk;
    logic [2:0] r_skip;
    logic       r_key_evt;

    ps2_rx #(
        .FILT    (FILT),
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_valid (w_rx_valid),
        .rx_byte  (w_rx_byte),
        .rx_err   (rx_err)
    );

    assign w_pos = map_ps2(r_ext, w_rx_byte);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                r_matrix[i] <= 8'hFF;
            end
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
            r_skip    <= '0;
            r_key_evt <= 1'b0;
        end else begin
            r_key_evt <= 1'b0;
            if (w_rx_valid) begin
                if (r_skip != 3'd0) begin
                    r_skip <= r_skip - 3'd1;
                end else if (w_rx_byte == c_code_ext) begin
                    r_ext <= 1'b1;
                end else if (w_rx_byte == c_code_brk) begin
                    r_brk <= 1'b1;
                end else if (w_rx_byte == c_code_pause) begin
                    r_skip <= c_pause_skip;
                end else if (!is_ignored(w_rx_byte)) begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    // Typematic repeats rewrite the same value and stay silent.
                    for (int i = 0; i < ROWS; i++) begin
                        if (w_pos.valid && w_pos.row == 4'(i) &&
                            r_matrix[i][w_pos.col] != r_brk) begin
                            r_matrix[i][w_pos.col] <= r_brk;
                            r_key_evt              <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_cols = 8'hFF;
        for (int i = 0; i < ROWS; i++) begin
            if (row == 4'(i)) begin
                w_cols = r_matrix[i];
            end
        end
    end

    assign cols    = w_cols;
    assign key_evt = r_key_evt;

endmodule

`default_nettype wire

// File: tb/tb_msx_ps2_keymatrix.sv
// ============================================================================
// tb_msx_ps2_keymatrix : directed PS/2 frames against hand-computed matrix reads
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_msx_ps2_keymatrix;

    localparam int          HALF     = 20;
    localparam logic [15:0] TB_TOUT  = 16'd1000;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] row;
    logic [7:0] cols;
    logic       rx_err;
    logic       key_evt;

    int n_chk;
    int n_err;
    int err_cyc;
    int evt_cyc;

    msx_ps2_keymatrix #(
        .FILT    (8),
        .TIMEOUT (TB_TOUT),
        .ROWS    (11)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .row      (row),
        .cols     (cols),
        .rx_err   (rx_err),
        .key_evt  (key_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high cycles of each pulse output; a single-cycle pulse adds exactly 1.
    always @(posedge clk) begin
        if (rx_err === 1'b1)  err_cyc <= err_cyc + 1;
        if (key_evt === 1'b1) evt_cyc <= evt_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        tick(40);
    endtask

    task automatic rd(input logic [3:0] r, input string tag, input logic [7:0] exp);
        row = r;
        #1;
        chk(tag, {24'd0, cols}, {24'd0, exp});
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        err_cyc  = 0;
        evt_cyc  = 0;
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        row      = 4'd0;
        tick(5);
        chk("reset_rx_err", {31'd0, rx_err}, 32'd0);
        chk("reset_key_evt", {31'd0, key_evt}, 32'd0);
        rst_n = 1'b1;
        tick(5);
        rd(4'd2,  "reset_row2",  8'hFF);
        rd(4'd15, "reset_row15", 8'hFF);

        send(8'h1C, 1'b0);
        rd(4'd2, "press_A_row2", 8'hBF);
        chk("press_A_evt", err_cyc + evt_cyc * 16, 32'd16);
        send(8'hF0, 1'b0); send(8'h1C, 1'b0);
        rd(4'd2, "release_A_row2", 8'hFF);

        send(8'hE0, 1'b0); send(8'h75, 1'b0);
        rd(4'd8,  "press_up_row8",  8'hDF);
        rd(4'd10, "press_up_row10", 8'hFF);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
        rd(4'd8, "release_up_row8", 8'hFF);
        send(8'hE0, 1'b0); send(8'h12, 1'b0);
        rd(4'd6, "fake_shift_row6", 8'hFF);
        chk("evt_after_arrows", evt_cyc, 32'd4);

        send(8'h1C, 1'b1);
        chk("parity_err", err_cyc, 32'd1);
        rd(4'd2, "parity_row2", 8'hFF);

        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        ps2_data = 1'b1;
        tick(int'(TB_TOUT) + 10);
        chk("timeout_err", err_cyc, 32'd2);
        send(8'h5A, 1'b0);
        rd(4'd7, "enter_row7", 8'h7F);
        send(8'h5A, 1'b0);
        rd(4'd7, "repeat_row7", 8'h7F);
        chk("repeat_no_evt", evt_cyc, 32'd5);
        rd(4'd11, "row11_oob", 8'hFF);

        send(8'h12, 1'b0); send(8'h1C, 1'b0);
        send(8'hE1, 1'b0); send(8'h14, 1'b0); send(8'h77, 1'b0); send(8'hE1, 1'b0);
        send(8'hF0, 1'b0); send(8'h14, 1'b0); send(8'hF0, 1'b0); send(8'h77, 1'b0);
        rd(4'd6, "pause_row6", 8'hFE);
        rd(4'd2, "pause_row2", 8'hBF);
        rd(4'd7, "pause_row7", 8'h7F);
        rd(4'd9, "pause_row9", 8'hFF);
        chk("pause_evt", evt_cyc, 32'd7);
        chk("pause_err", err_cyc, 32'd2);

        ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b0);
        rst_n = 1'b0;
        #1;
        rd(4'd6, "midreset_row6", 8'hFF);
        rd(4'd2, "midreset_row2", 8'hFF);
        rd(4'd7, "midreset_row7", 8'hFF);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(10);
        send(8'h1C, 1'b0);
        rd(4'd2, "after_reset_A", 8'hBF);
        rd(4'd6, "after_reset_row6", 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
